// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754-style multiplier, RNE rounding, flush-to-zero, valid/ready flow control
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_t;
    logic               r_v1, r_v2, r_v3;
    logic               r_s1, r_s2, r_inv1, r_inv2;
    logic signed [EW-1:0] r_e1, r_e2;
    logic [MAN_W:0]     r_ma1, r_mb1;
    logic [PW-1:0]      r_prod;
    kind_t              r_kind1, r_kind2;
    logic [W-1:0]       r_result;
    logic [3:0]         r_flags;
    logic               w_rdy1, w_rdy2, w_rdy3;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_fa, w_fb;
    logic               w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_inv;
    kind_t              w_kind;
    logic signed [EW-1:0] w_esum;
    assign w_rdy3    = out_ready | ~r_v3;
    assign w_rdy2    = ~r_v2 | w_rdy3;
    assign w_rdy1    = ~r_v1 | w_rdy2;
    assign in_ready  = w_rdy1;
    assign out_valid = r_v3;
    assign result    = r_result;
    assign flags     = r_flags;
    assign w_ea   = a[W-2:MAN_W];
    assign w_eb   = b[W-2:MAN_W];
    assign w_fa   = a[MAN_W-1:0];
    assign w_fb   = b[MAN_W-1:0];
    assign w_za   = w_ea == '0;
    assign w_zb   = w_eb == '0;
    assign w_ia   = &w_ea & (w_fa == '0);
    assign w_ib   = &w_eb & (w_fb == '0);
    assign w_na   = &w_ea & |w_fa;
    assign w_nb   = &w_eb & |w_fb;
    assign w_inv  = (w_ia & w_zb) | (w_ib & w_za);
    assign w_kind = (w_na | w_nb | w_inv) ? K_NAN : (w_ia | w_ib) ? K_INF : (w_za | w_zb) ? K_ZERO : K_NUM;
    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
    logic               w_msb, w_g, w_st, w_rnd, w_ovf, w_unf, w_inx;
    logic [PW-2:0]      w_norm;
    logic [MAN_W-1:0]   w_frac;
    logic [MAN_W:0]     w_fr;
    logic signed [EW-1:0] w_exp;
    logic [W-1:0]       w_res;
    logic [3:0]         w_flg;
    assign w_msb  = r_prod[PW-1];
    assign w_norm = w_msb ? r_prod[PW-2:0] : {r_prod[PW-3:0], 1'b0};
    assign w_frac = w_norm[PW-2 -: MAN_W];
    assign w_g    = w_norm[MAN_W];
    assign w_st   = |w_norm[MAN_W-1:0];
    assign w_rnd  = w_g & (w_st | w_frac[0]);
    assign w_fr   = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_rnd};
    // a rounding carry leaves w_fr[MAN_W-1:0] all zero, so only the exponent needs bumping
    assign w_exp  = r_e2 + $signed({{(EW-1){1'b0}}, w_msb}) + $signed({{(EW-1){1'b0}}, w_fr[MAN_W]});
    assign w_ovf  = w_exp >= EMAX;
    assign w_unf  = w_exp[EW-1] | (w_exp == '0);
    assign w_inx  = w_g | w_st;
    assign w_res  = (r_kind2 == K_NAN)  ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                    (r_kind2 == K_INF)  ? {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                    (r_kind2 == K_ZERO) ? {r_s2, {(W-1){1'b0}}} :
                    w_ovf               ? {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                    w_unf               ? {r_s2, {(W-1){1'b0}}} :
                                          {r_s2, w_exp[EXP_W-1:0], w_fr[MAN_W-1:0]};
    assign w_flg  = (r_kind2 == K_NAN) ? {r_inv2, 3'b000} :
                    (r_kind2 == K_NUM) ? {1'b0, w_ovf, w_unf, w_inx | w_ovf | w_unf} : 4'b0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_rdy1) r_v1 <= in_valid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) r_v3 <= r_v2;
            if (w_rdy3 && r_v2) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (in_valid && w_rdy1) begin
            r_s1    <= a[W-1] ^ b[W-1];
            r_e1    <= w_esum;
            r_ma1   <= {1'b1, w_fa};
            r_mb1   <= {1'b1, w_fb};
            r_kind1 <= w_kind;
            r_inv1  <= w_inv;
        end
        if (r_v1 && w_rdy2) begin
            r_s2    <= r_s1;
            r_e2    <= r_e1;
            r_prod  <= r_ma1 * r_mb1;
            r_kind2 <= r_kind1;
            r_inv2  <= r_inv1;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed single-precision vectors, backpressure and mid-flight reset checks
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [3:0]  flags;
    int          n_cmp = 0;
    int          n_bad = 0;
    always #5 clk = ~clk;
    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );
    task automatic run_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("FAIL %s latency: got %0d want 3", nm, lat); end
        n_cmp++;
        if (result !== er) begin n_bad++; $display("FAIL %s result: got %h want %h", nm, result, er); end
        n_cmp++;
        if (flags !== ef) begin n_bad++; $display("FAIL %s flags: got %b want %b", nm, flags, ef); end
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        #12;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (result !== 32'h0) begin n_bad++; $display("FAIL reset result: got %h want 0", result); end
        n_cmp++;
        if (flags !== 4'h0) begin n_bad++; $display("FAIL reset flags: got %b want 0000", flags); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask
    task automatic test_normal();
        run_op("2x4", 32'h40000000, 32'h40800000, 32'h41000000, 4'b0000);
        run_op("1ulp_sq", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_op("1.5sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        run_op("neg_mix", 32'hC0400000, 32'h40A00000, 32'hC1700000, 4'b0000);
    endtask
    task automatic test_specials();
        run_op("inf_x_0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_op("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_op("nzero_x_5", 32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000);
        run_op("nan_x_1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    endtask
    task automatic test_range();
        run_op("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        run_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    endtask
    task automatic test_back_to_back();
        logic [31:0] bv [6];
        logic [31:0] ev [6];
        int sent, got, last_out;
        bv = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        ev = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};
        sent = 0; got = 0; last_out = -1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid = sent < 6;
            a = 32'h40000000;
            b = (sent < 6) ? bv[sent] : 32'h0;
            out_ready = cyc >= 5;
            @(negedge clk);
            if (cyc == 4) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 3) begin
                    n_bad++; $display("FAIL bp_fill: in_ready=%b sent=%0d want in_ready=0 sent=3", in_ready, sent);
                end
            end
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (result !== ev[0] || flags !== 4'h0) begin
                    n_bad++; $display("FAIL bp_hold: got %h/%b want %h/0000", result, flags, ev[0]);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (result !== ev[got]) begin
                    n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", got, result, ev[got]);
                end
                if (got > 0) begin
                    n_cmp++;
                    if (cyc != last_out + 1) begin
                        n_bad++; $display("FAIL bp_gap[%0d]: got cycle %0d want %0d", got, cyc, last_out + 1);
                    end
                end
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", got); end
    endtask
    task automatic test_reset_flight();
        int stale;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h40000000; b = 32'h40400000;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre out_valid: got %b want 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            n_bad++; $display("FAIL rst_flight: got v=%b r=%h f=%b want 0/0/0", out_valid, result, flags);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0) begin n_bad++; $display("FAIL rst_stale: got %0d want 0", stale); end
        run_op("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
    endtask
    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_back_to_back();
        test_reset_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style binary floating-point multiplier.
- Successor to the team's combinational single-precision multiplier. Adds:
  - configurable exponent/mantissa widths
  - a 3-stage pipeline with valid/ready flow control
  - round-to-nearest-even
  - correct sign on special values
  - NaN handling and exception flags
- Sits between operand-issue logic and the result writeback/FIFO in the arithmetic datapath.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair a/b presented
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A, {sign, exponent, fraction}
- b  in  W  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream accepts result this cycle
- result  out  W  product
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid=0, result=0, flags=0. in_ready=1 one cycle after release. Reset mid-operation discards all in-flight operations; nothing is emitted afterwards.
- Handshake:
  - Transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
  - Per stage: stage k advances when its successor is empty or advancing (ready_k = !valid_k | ready_{k+1}); ready_3 = out_ready.
  - in_ready = ready_1 (combinational from out_ready and stage valids).
  - result/flags hold stable while out_valid=1 and out_ready=0.
  - Strict in-order delivery; no drops, no duplicates.
- Latency: exactly 3 cycles accept-to-out_valid with no backpressure. Throughput: 1 op/cycle.
- S1, unpack/classify: split fields; classify zero (exp=0, subnormals flushed to zero), inf (exp all 1s, frac=0), NaN (exp all 1s, frac≠0). Sign s=sa^sb. Compute biased exponent sum ea+eb-bias, signed, EXP_W+2 bits.
- S2, multiply: significands {1,frac} of MAN_W+1 bits multiplied into a 2*MAN_W+2-bit product, registered.
- S3, normalise/round/pack:
  - If product MSB=1, shift right 1 and exponent+1.
  - Guard, round and sticky bits from the discarded bits; round-to-nearest, ties-to-even.
  - Rounding carry-out renormalises (exponent+1, fraction=0).
- Exponent range after rounding:
  - biased exp ≥ all-1s: result = ±inf; overflow=1, inexact=1.
  - biased exp ≤ 0: result = ±0 (flush-to-zero); underflow=1, inexact=1.
- Specials (priority order):
  1. any NaN, or inf×zero: canonical quiet NaN {0, all-1s exp, 1, zeros}, invalid=1 (inf×zero only; NaN input gives invalid=0).
  2. inf×finite nonzero, or inf×inf: {s, all-1s, 0}, no flags.
  3. zero×finite: {s, 0, 0}, no flags.
- inexact=1 whenever any discarded bit is nonzero in the normal path.

Test Plan (defaults EXP_W=8, MAN_W=23):
- a=0x40000000 (2.0), b=0x40800000 (4.0), out_ready=1 → 3 cycles later result=0x41000000, flags=0000.
- a=0x3F800001, b=0x3F800001 → result=0x3F800002, inexact=1. Also a=0x3FC00000, b=0x3FC00000 → 0x40100000, flags=0000.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000×0x40000000 → 0xFF800000.
  - 0x80000000×0x40A00000 → 0x80000000.
  - 0x7FC00001×1.0 → 0x7FC00000, invalid=0.
- Range limits:
  - 0x7F7FFFFF×0x40000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000×0x3F000000 → 0x00000000, underflow=1, inexact=1.
- Backpressure: stream 6 ops back-to-back with out_ready=0 for 5 cycles → in_ready falls after 3 ops are held, result stays stable, then all 6 results emerge in order with no gaps once out_ready=1.
- Reset: assert rst_n=0 with 3 ops in flight → out_valid=0 at once; after release, no stale results appear and a new op completes in 3 cycles.
